// File: rtl/cordic_iterative_rotator_pkg.sv
// Shared CORDIC settings: data format, iteration count, gain pre-compensation,
// angle constants and the arctangent table used by the iterative rotator.
package cordic_iterative_rotator_pkg;

  localparam int SIZE_DATA       = 16;
  localparam int SIZE_FRAC       = 16;
  localparam int CORDIC_STAGES   = 16;

  // 0.607252935 * 2^16, loaded into x so the CORDIC gain cancels out.
  localparam logic signed [31:0] CORDIC_K_SCALED = 32'sd39797;

  localparam logic signed [31:0] PI_SCALED      = 32'sd205887;
  localparam logic signed [31:0] HALF_PI_SCALED = 32'sd102944;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } cordic_state_t;

  // round(atan(2^-i) * 2^16); entries past the table depth are zero.
  function automatic logic signed [31:0] atan_table(input int idx);
    case (idx)
      0:       atan_table = 32'sd51472;
      1:       atan_table = 32'sd30386;
      2:       atan_table = 32'sd16055;
      3:       atan_table = 32'sd8150;
      4:       atan_table = 32'sd4091;
      5:       atan_table = 32'sd2047;
      6:       atan_table = 32'sd1024;
      7:       atan_table = 32'sd512;
      8:       atan_table = 32'sd256;
      9:       atan_table = 32'sd128;
      10:      atan_table = 32'sd64;
      11:      atan_table = 32'sd32;
      12:      atan_table = 32'sd16;
      13:      atan_table = 32'sd8;
      14:      atan_table = 32'sd4;
      15:      atan_table = 32'sd2;
      default: atan_table = 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_micro_rotation.sv
// One combinational CORDIC micro-rotation in rotation mode.
// Ports:
//   x, y, z        current vector and residual angle (signed)
//   shift          iteration index i, used as the arithmetic shift amount
//   atan_c         atan(2^-i) in the same fixed-point format as z
//   x_next, y_next, z_next  rotated vector and updated residual angle
module cordic_micro_rotation #(
  parameter int FULL_SIZE = 32,
  parameter int IDX_W     = 4
) (
  input  logic signed [FULL_SIZE-1:0] x,
  input  logic signed [FULL_SIZE-1:0] y,
  input  logic signed [FULL_SIZE-1:0] z,
  input  logic        [IDX_W-1:0]     shift,
  input  logic signed [FULL_SIZE-1:0] atan_c,
  output logic signed [FULL_SIZE-1:0] x_next,
  output logic signed [FULL_SIZE-1:0] y_next,
  output logic signed [FULL_SIZE-1:0] z_next
);

  logic                        dir_pos;
  logic signed [FULL_SIZE-1:0] x_sh;
  logic signed [FULL_SIZE-1:0] y_sh;

  // Rotate towards zero residual: positive direction when z >= 0.
  assign dir_pos = ~z[FULL_SIZE-1];
  assign x_sh    = x >>> shift;
  assign y_sh    = y >>> shift;

  assign x_next = dir_pos ? (x - y_sh)   : (x + y_sh);
  assign y_next = dir_pos ? (y + x_sh)   : (y - x_sh);
  assign z_next = dir_pos ? (z - atan_c) : (z + atan_c);

endmodule

// File: rtl/cordic_iterative_rotator.sv
// Iterative rotation-mode CORDIC: cos/sin of a signed fixed-point angle in
// radians, one micro-rotation per clock, valid/ready on both sides.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   in_valid   angle_in valid
//   in_ready   engine idle, can accept an angle
//   angle_in   signed angle, nominal range [-pi, +pi]
//   out_valid  cos_out/sin_out valid, held until out_ready
//   out_ready  consumer accepts result
//   cos_out    signed cosine
//   sin_out    signed sine
//
// state  | meaning
// IDLE   | waiting for an angle; in_ready high
// ROTATE | one micro-rotation per clock, iter = 0 .. STAGES-1
// DONE   | result presented, held until out_ready
module cordic_iterative_rotator
  import cordic_iterative_rotator_pkg::*;
#(
  parameter int                        FULL_SIZE = SIZE_DATA + SIZE_FRAC,
  parameter int                        STAGES    = CORDIC_STAGES,
  parameter logic signed [FULL_SIZE-1:0] K_SCALED  = FULL_SIZE'(CORDIC_K_SCALED)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [FULL_SIZE-1:0] angle_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [FULL_SIZE-1:0] cos_out,
  output logic signed [FULL_SIZE-1:0] sin_out
);

  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic signed [FULL_SIZE-1:0] PI_S      = FULL_SIZE'(PI_SCALED);
  localparam logic signed [FULL_SIZE-1:0] HALF_PI_S = FULL_SIZE'(HALF_PI_SCALED);
  localparam logic        [IDX_W-1:0]     LAST_ITER = IDX_W'(STAGES - 1);

  cordic_state_t               state;
  logic signed [FULL_SIZE-1:0] x_q;
  logic signed [FULL_SIZE-1:0] y_q;
  logic signed [FULL_SIZE-1:0] z_q;
  logic        [IDX_W-1:0]     iter;
  logic                        neg;

  logic signed [FULL_SIZE-1:0] angle_clamped;
  logic signed [FULL_SIZE-1:0] pre_z;
  logic                        pre_neg;
  logic signed [FULL_SIZE-1:0] atan_c;
  logic signed [FULL_SIZE-1:0] x_next;
  logic signed [FULL_SIZE-1:0] y_next;
  logic signed [FULL_SIZE-1:0] z_next;

  // CORDIC only converges for |z| <= ~1.74 rad, so angles beyond +/-pi/2 are
  // folded by pi and the result sign is corrected on the way out.
  always_comb begin
    angle_clamped = angle_in;
    if (angle_in > PI_S) begin
      angle_clamped = PI_S;
    end else if (angle_in < -PI_S) begin
      angle_clamped = -PI_S;
    end

    pre_z   = angle_clamped;
    pre_neg = 1'b0;
    if (angle_clamped > HALF_PI_S) begin
      pre_z   = angle_clamped - PI_S;
      pre_neg = 1'b1;
    end else if (angle_clamped < -HALF_PI_S) begin
      pre_z   = angle_clamped + PI_S;
      pre_neg = 1'b1;
    end
  end

  assign atan_c = FULL_SIZE'(atan_table(int'(iter)));

  cordic_micro_rotation #(
    .FULL_SIZE (FULL_SIZE),
    .IDX_W     (IDX_W)
  ) u_micro_rotation (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .shift  (iter),
    .atan_c (atan_c),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter      <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is registered, so it comes up one clock after reset release.
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x_q      <= K_SCALED;
            y_q      <= '0;
            z_q      <= pre_z;
            neg      <= pre_neg;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= ROTATE;
          end
        end

        ROTATE: begin
          x_q <= x_next;
          y_q <= y_next;
          z_q <= z_next;
          if (iter == LAST_ITER) begin
            // Result registered straight from the last micro-rotation.
            cos_out   <= neg ? -x_next : x_next;
            sin_out   <= neg ? -y_next : y_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            iter <= iter + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iterative_rotator.sv
module tb_cordic_iterative_rotator;

  localparam int TOL       = 16;
  localparam int PI_S      = 205887;
  localparam int WAIT_MAX  = 60;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] angle_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;

  typedef struct {
    int a;
    int c;
    int s;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  cordic_iterative_rotator dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  // Reference: ideal cos/sin of the clamped angle, rounded to Q16.16.
  function automatic exp_t model(input int a);
    exp_t e;
    int   ac;
    real  r;
    ac = a;
    if (ac > PI_S) ac = PI_S;
    if (ac < -PI_S) ac = -PI_S;
    r = real'(ac) / 65536.0;
    e.a = a;
    e.c = int'(65536.0 * $cos(r));
    e.s = int'(65536.0 * $sin(r));
    return e;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Waits for in_ready, presents one angle for exactly the accept cycle and
  // records the expected result.
  task automatic send_angle(input int a, output int acc_cyc, output bit ok);
    int w;
    w  = 0;
    ok = 1'b1;
    acc_cyc = 0;
    while (in_ready !== 1'b1 && w < WAIT_MAX) begin
      @(posedge clk); #1;
      w++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL send_wait angle=%0d in_ready=%b required 1", a, in_ready);
      ok = 1'b0;
      return;
    end
    angle_in = a;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc_cnt;
    in_valid = 1'b0;
    sb.push_back(model(a));
  endtask

  // Called 1 ns after the accept edge; cyc counts that cycle as 1.
  task automatic wait_valid(output int cyc, output bit timed_out);
    cyc = 1;
    timed_out = 1'b0;
    while (out_valid !== 1'b1 && cyc < WAIT_MAX) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (out_valid !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL out_valid_timeout out_valid=%b required 1", out_valid);
      timed_out = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_vec++;
    if (cos_out !== 32'sd0 || sin_out !== 32'sd0) begin
      n_err++; $display("FAIL rst_outputs cos=%0d sin=%0d want 0 0", cos_out, sin_out);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    int acc, cyc; bit ok, to; exp_t e;
    out_ready = 1'b1;
    send_angle(0, acc, ok);
    if (!ok) return;
    wait_valid(cyc, to);
    if (to) return;
    n_vec++;
    if (cyc !== 17) begin n_err++; $display("FAIL latency got cycle %0d want 17", cyc); end
    e = sb.pop_front();
    n_vec++;
    if (iabs(int'(cos_out) - e.c) > TOL || iabs(int'(sin_out) - e.s) > TOL) begin
      n_err++;
      $display("FAIL zero_angle cos=%0d sin=%0d want %0d %0d", cos_out, sin_out, e.c, e.s);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL retire out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_angles();
    int angles[10] = '{102944, 205887, -51472, -102944, -205887,
                       150000, -150000, 300000, -400000, 51472};
    int acc, cyc; bit ok, to; exp_t e;
    out_ready = 1'b1;
    foreach (angles[k]) begin
      send_angle(angles[k], acc, ok);
      if (!ok) continue;
      wait_valid(cyc, to);
      if (to) begin
        void'(sb.pop_front());
        continue;
      end
      e = sb.pop_front();
      n_vec++;
      if (iabs(int'(cos_out) - e.c) > TOL) begin
        n_err++; $display("FAIL angle_cos a=%0d got %0d want %0d", e.a, cos_out, e.c);
      end
      n_vec++;
      if (iabs(int'(sin_out) - e.s) > TOL) begin
        n_err++; $display("FAIL angle_sin a=%0d got %0d want %0d", e.a, sin_out, e.s);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int acc, cyc; bit ok, to; exp_t e;
    logic signed [31:0] c0, s0;
    out_ready = 1'b0;
    send_angle(40000, acc, ok);
    if (!ok) begin out_ready = 1'b1; return; end
    wait_valid(cyc, to);
    if (to) begin out_ready = 1'b1; void'(sb.pop_front()); return; end
    c0 = cos_out;
    s0 = sin_out;
    repeat (5) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cos_out !== c0 || sin_out !== s0) begin
        n_err++;
        $display("FAIL bp_hold valid=%b ready=%b cos=%0d sin=%0d want 1 0 %0d %0d",
                 out_valid, in_ready, cos_out, sin_out, c0, s0);
      end
    end
    e = sb.pop_front();
    n_vec++;
    if (iabs(int'(cos_out) - e.c) > TOL || iabs(int'(sin_out) - e.s) > TOL) begin
      n_err++; $display("FAIL bp_value cos=%0d sin=%0d want %0d %0d", cos_out, sin_out, e.c, e.s);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_busy();
    int acc, cyc; bit ok, to; exp_t e;
    out_ready = 1'b1;
    send_angle(0, acc, ok);
    if (!ok) return;
    in_valid = 1'b1;
    angle_in = 77777;
    repeat (8) begin
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
    end
    in_valid = 1'b0;
    wait_valid(cyc, to);
    if (to) begin void'(sb.pop_front()); return; end
    e = sb.pop_front();
    n_vec++;
    if (iabs(int'(cos_out) - e.c) > TOL || iabs(int'(sin_out) - e.s) > TOL) begin
      n_err++; $display("FAIL busy_value cos=%0d sin=%0d want %0d %0d", cos_out, sin_out, e.c, e.s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int angles[3] = '{-30000, 90000, -180000};
    int acc, prev_acc, cyc; bit ok, to; exp_t e;
    out_ready = 1'b1;
    prev_acc = -1;
    foreach (angles[k]) begin
      send_angle(angles[k], acc, ok);
      if (!ok) return;
      if (prev_acc >= 0) begin
        n_vec++;
        if (acc - prev_acc !== 18) begin
          n_err++; $display("FAIL throughput spacing got %0d want 18", acc - prev_acc);
        end
      end
      prev_acc = acc;
      wait_valid(cyc, to);
      if (to) begin void'(sb.pop_front()); return; end
      e = sb.pop_front();
      n_vec++;
      if (iabs(int'(cos_out) - e.c) > TOL || iabs(int'(sin_out) - e.s) > TOL) begin
        n_err++; $display("FAIL b2b_value a=%0d cos=%0d sin=%0d want %0d %0d",
                          e.a, cos_out, sin_out, e.c, e.s);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int acc, cyc; bit ok, to; exp_t e;
    out_ready = 1'b1;
    send_angle(60000, acc, ok);
    if (!ok) return;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    sb.delete();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || cos_out !== 32'sd0 || sin_out !== 32'sd0) begin
      n_err++;
      $display("FAIL abort_outputs valid=%b ready=%b cos=%0d sin=%0d want 0 0 0 0",
               out_valid, in_ready, cos_out, sin_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    send_angle(0, acc, ok);
    if (!ok) return;
    wait_valid(cyc, to);
    if (to) begin void'(sb.pop_front()); return; end
    n_vec++;
    if (cyc !== 17) begin n_err++; $display("FAIL abort_latency got cycle %0d want 17", cyc); end
    e = sb.pop_front();
    n_vec++;
    if (iabs(int'(cos_out) - e.c) > TOL || iabs(int'(sin_out) - e.s) > TOL) begin
      n_err++; $display("FAIL abort_next cos=%0d sin=%0d want %0d %0d", cos_out, sin_out, e.c, e.s);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_angles();
    test_backpressure();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
